// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Segment codes are {a,b,c,d,e,f,g} with a at bit 6, active-high.
package disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  localparam logic [6:0] SEG_OFF  = 7'b0;
  localparam logic [5:0] ENB_NONE = 6'b111111;

  typedef enum logic {ST_BLANK, ST_SHOW} scan_state_e;

  // Active-low one-cold enable for digit idx.
  function automatic logic [5:0] enb_sel(input logic [2:0] idx);
    return ~(6'b000001 << idx);
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Bundle of display data inputs and pin outputs of the scan controller.
// master drives the digit data, slave drives the display pins.
interface disp_scan_ctrl_if;
  import disp_pkg::*;

  logic [NUM_DIGITS*4-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blink;
  logic                    lzb;
  logic                    en;
  logic [NUM_DIGITS-1:0]   seg_enb;
  logic                    seg_dp;
  logic [6:0]              seg;
  logic                    frame_start;

  modport master (
    output digits, dp, blink, lzb, en,
    input  seg_enb, seg_dp, seg, frame_start
  );

  modport slave (
    input  digits, dp, blink, lzb, en,
    output seg_enb, seg_dp, seg, frame_start
  );

endinterface

// File: rtl/disp_scan_ctrl_seg7_dec.sv
// seg7_dec: combinational hex code to 7-segment pattern decoder.
// Ports: i_code (4-bit value), o_seg ({a..g}, active-high).
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    unique case (i_code)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: round-robin 6-digit scan with blank gap, frame shadowing,
// leading-zero blanking, dp and blink. Inputs i_*, registered pins o_*.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int P_NUM_SCAN     = 50000,
  parameter int P_BLANK_CYC    = 500,
  parameter int P_BLINK_FRAMES = 83
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] i_digits,
  input  logic [5:0]  i_dp,
  input  logic [5:0]  i_blink,
  input  logic        i_lzb,
  input  logic        i_en,
  output logic [5:0]  o_seg_enb,
  output logic        o_seg_dp,
  output logic [6:0]  o_seg,
  output logic        o_frame_start
);

  localparam int CW = (P_NUM_SCAN > 1) ? $clog2(P_NUM_SCAN) : 1;
  localparam int FW = $clog2(P_BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(P_NUM_SCAN - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(P_BLANK_CYC - 1);
  localparam logic [FW-1:0] FR_WRAP    = FW'(P_BLINK_FRAMES);

  // cnt/idx/state describe the slot position the next output edge renders.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  scan_state_e   state_q, state_d;
  logic          run_q, run_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  logic [NUM_DIGITS-1:0][3:0] sh_dig_q, sh_dig_d;
  logic [5:0] sh_dp_q, sh_dp_d;
  logic [5:0] sh_blink_q, sh_blink_d;
  logic [5:0] sh_lzm_q, sh_lzm_d;

  logic [5:0] seg_enb_q, seg_enb_d;
  logic [6:0] seg_q, seg_d;
  logic       seg_dp_q, seg_dp_d;
  logic       fs_q, fs_d;

  logic       frame_edge;
  logic       zero_run;
  logic [5:0] lzm_now;
  logic [3:0] cur_code;
  logic [6:0] dec_seg;
  logic       blink_off;

  // A digit is blanked while it and every higher digit are zero.
  always_comb begin
    zero_run = 1'b1;
    lzm_now  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (i_digits[4*k +: 4] == 4'h0);
      lzm_now[k] = i_lzb & zero_run;
    end
  end

  assign frame_edge = (cnt_q == '0) && (idx_q == 3'd0);
  assign cur_code   = sh_dig_q[idx_q];
  assign blink_off  = phase_q & sh_blink_q[idx_q];

  seg7_dec u_dec (
    .i_code (cur_code),
    .o_seg  (dec_seg)
  );

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    state_d    = state_q;
    run_d      = 1'b1;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    sh_blink_d = sh_blink_q;
    sh_lzm_d   = sh_lzm_q;
    seg_enb_d  = ENB_NONE;
    seg_d      = SEG_OFF;
    seg_dp_d   = 1'b0;
    fs_d       = frame_edge;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    unique case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (cnt_q == CNT_LAST)   state_d = ST_BLANK;
    endcase

    if (frame_edge) begin
      sh_dig_d   = i_digits;
      sh_dp_d    = i_dp;
      sh_blink_d = i_blink;
      sh_lzm_d   = lzm_now;
      // The first frame after reset starts the count, it does not advance it.
      if (run_q) begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_d == FR_WRAP) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end
      end
    end

    if (state_q == ST_SHOW && i_en) begin
      seg_enb_d = enb_sel(idx_q);
      seg_d     = (sh_lzm_q[idx_q] | blink_off) ? SEG_OFF : dec_seg;
      seg_dp_d  = sh_dp_q[idx_q] & ~blink_off;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      state_q    <= ST_BLANK;
      run_q      <= 1'b0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      sh_dig_q   <= '0;
      sh_dp_q    <= '0;
      sh_blink_q <= '0;
      sh_lzm_q   <= '0;
      seg_enb_q  <= ENB_NONE;
      seg_q      <= SEG_OFF;
      seg_dp_q   <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      run_q      <= run_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      sh_dig_q   <= sh_dig_d;
      sh_dp_q    <= sh_dp_d;
      sh_blink_q <= sh_blink_d;
      sh_lzm_q   <= sh_lzm_d;
      seg_enb_q  <= seg_enb_d;
      seg_q      <= seg_d;
      seg_dp_q   <= seg_dp_d;
      fs_q       <= fs_d;
    end
  end

  assign o_seg_enb     = seg_enb_q;
  assign o_seg         = seg_q;
  assign o_seg_dp      = seg_dp_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: frame-position reference model plus directed
// literal checks and randomized data, enable and reset traffic.
module tb_disp_scan_ctrl;

  localparam int N  = 8;
  localparam int B  = 2;
  localparam int BF = 2;
  localparam int FR = 6 * N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(
    .P_NUM_SCAN     (N),
    .P_BLANK_CYC    (B),
    .P_BLINK_FRAMES (BF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_digits      (bus.digits),
    .i_dp          (bus.dp),
    .i_blink       (bus.blink),
    .i_lzb         (bus.lzb),
    .i_en          (bus.en),
    .o_seg_enb     (bus.seg_enb),
    .o_seg_dp      (bus.seg_dp),
    .o_seg         (bus.seg),
    .o_frame_start (bus.frame_start)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model: position t within frame f since reset release.
  bit          m_valid = 0;
  bit          m_act   = 0;
  int          m_t     = 0;
  int          m_f     = 0;
  logic [23:0] m_dig;
  logic [5:0]  m_dp, m_bl, m_lzm;
  logic [5:0]  exp_enb;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fs;
  int          mk, ms;
  bit          m_off, allz;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s f=%0d c=%0d actual=%0h required=%0h",
               name, m_f, m_t, act, req);
    end
  endtask

  always @(posedge clk) begin
    m_valid = 1;
    exp_enb = 6'h3f;
    exp_seg = 7'h0;
    exp_dp  = 1'b0;
    exp_fs  = 1'b0;
    if (!rst_n) begin
      m_act = 0;
    end else begin
      if (!m_act) begin
        m_act = 1; m_t = 0; m_f = 0;
      end else begin
        m_t++;
        if (m_t == FR) begin m_t = 0; m_f++; end
      end
      if (m_t == 0) begin
        m_dig = bus.digits; m_dp = bus.dp; m_bl = bus.blink;
        m_lzm = '0; allz = 1;
        for (int k = 5; k >= 1; k--) begin
          allz = allz && (bus.digits[4*k +: 4] == 4'h0);
          m_lzm[k] = bus.lzb && allz;
        end
      end
      mk     = m_t / N;
      ms     = m_t % N;
      m_off  = (((m_f / BF) % 2) == 1) && m_bl[mk];
      exp_fs = (m_t == 0);
      if (ms >= B && bus.en) begin
        exp_enb[mk] = 1'b0;
        exp_seg = (m_lzm[mk] || m_off) ? 7'h0 : seg_tab[m_dig[4*mk +: 4]];
        exp_dp  = m_dp[mk] && !m_off;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("enb", 32'(bus.seg_enb), 32'(exp_enb));
      chk("seg", 32'(bus.seg), 32'(exp_seg));
      chk("dp",  32'(bus.seg_dp), 32'(exp_dp));
      chk("fs",  32'(bus.frame_start), 32'(exp_fs));
    end
  end

  task automatic wait_c(input int f, input int c);
    int  n = 0;
    bit  hit = 0;
    do begin
      @(negedge clk);
      n++;
      hit = m_act && m_f == f && m_t == c;
    end while (!hit && n < 3000);
    if (!hit) begin
      checks++; failures++;
      $display("FAIL wait_c f=%0d c=%0d actual=timeout required=reached", f, c);
    end
  endtask

  function automatic logic [23:0] rnd_digits();
    logic [23:0] v;
    for (int i = 0; i < 6; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.digits = 24'h123456; bus.dp = 6'b0; bus.blink = 6'b0;
    bus.lzb = 1'b0; bus.en = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_enb", 32'(bus.seg_enb), 32'h3f);
    chk("rst_fs", 32'(bus.frame_start), 32'h0);
    rst_n = 1'b1;

    wait_c(0, 0);  chk("fs0", 32'(bus.frame_start), 32'h1);
    wait_c(0, 1);  chk("gap", 32'(bus.seg_enb), 32'h3f);
    wait_c(0, 3);  chk("d0_enb", 32'(bus.seg_enb), 32'b111110);
                   chk("d0_seg", 32'(bus.seg), 32'b1011111);
    wait_c(0, 45); chk("d5_enb", 32'(bus.seg_enb), 32'b011111);
                   chk("d5_seg", 32'(bus.seg), 32'b0110000);
    wait_c(1, 0);  chk("fs48", 32'(bus.frame_start), 32'h1);

    wait_c(1, 20); bus.digits = 24'h999999;
    wait_c(1, 28); chk("shadow_enb", 32'(bus.seg_enb), 32'b110111);
                   chk("shadow_seg", 32'(bus.seg), 32'b1111001);
    wait_c(2, 4);  chk("new_frame", 32'(bus.seg), 32'b1111011);
    bus.digits = 24'h000700; bus.lzb = 1'b1; bus.dp = 6'b100000;

    wait_c(3, 3);  chk("lzb_d0", 32'(bus.seg), 32'b1111110);
    wait_c(3, 11); chk("lzb_d1", 32'(bus.seg), 32'b1111110);
    wait_c(3, 19); chk("lzb_d2", 32'(bus.seg), 32'b1110000);
    wait_c(3, 27); chk("lzb_d3", 32'(bus.seg), 32'h0);
    wait_c(3, 35); chk("lzb_d4", 32'(bus.seg), 32'h0);
    wait_c(3, 43); chk("lzb_d5", 32'(bus.seg), 32'h0);
                   chk("lzb_dp5", 32'(bus.seg_dp), 32'h1);

    wait_c(4, 4);  bus.en = 1'b0;
    wait_c(4, 5);  chk("en_off", 32'(bus.seg_enb), 32'h3f);
    wait_c(4, 20); bus.en = 1'b1;
    wait_c(4, 22); chk("en_back", 32'(bus.seg_enb), 32'b111011);
                   chk("en_seg", 32'(bus.seg), 32'b1110000);
    wait_c(5, 0);  chk("fs_en", 32'(bus.frame_start), 32'h1);

    wait_c(5, 30); rst_n = 1'b0;
    bus.digits = 24'h000008; bus.lzb = 1'b0;
    bus.dp = 6'b000011; bus.blink = 6'b000001;
    @(negedge clk);
    chk("mid_rst_enb", 32'(bus.seg_enb), 32'h3f);
    chk("mid_rst_fs", 32'(bus.frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_c(0, 0);  chk("rst_fs", 32'(bus.frame_start), 32'h1);
    wait_c(0, 3);  chk("bl_f0", 32'(bus.seg), 32'b1111111);
    wait_c(1, 3);  chk("bl_f1", 32'(bus.seg), 32'b1111111);
    wait_c(2, 3);  chk("bl_f2_seg", 32'(bus.seg), 32'h0);
                   chk("bl_f2_dp", 32'(bus.seg_dp), 32'h0);
                   chk("bl_f2_enb", 32'(bus.seg_enb), 32'b111110);
    wait_c(2, 11); chk("bl_d1", 32'(bus.seg), 32'b1111110);
                   chk("bl_d1_dp", 32'(bus.seg_dp), 32'h1);
    wait_c(3, 3);  chk("bl_f3", 32'(bus.seg), 32'h0);
    wait_c(4, 3);  chk("bl_f4", 32'(bus.seg), 32'b1111111);
                   chk("bl_f4_dp", 32'(bus.seg_dp), 32'h1);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 4) bus.digits = rnd_digits();
      if ($urandom_range(0, 99) < 3) bus.dp = 6'($urandom);
      if ($urandom_range(0, 99) < 3) bus.blink = 6'($urandom);
      if ($urandom_range(0, 99) < 3) bus.lzb = 1'($urandom);
      if ($urandom_range(0, 99) < 5) bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexing scheduler for the 6-digit 7-segment display: shares the common o_seg/o_seg_dp bus among six digit enables in a fixed round-robin. It inserts an anti-ghosting blank gap per slot, double-buffers digit data per frame (no tearing), and applies leading-zero blanking, per-digit decimal points and per-digit blink. It sits between the counter/NCO datapath and the display pins.

Parameters:
P_NUM_SCAN, 50000, clocks per digit slot (1 ms at 50 MHz); must be >= P_BLANK_CYC+1
P_BLANK_CYC, 500, blank clocks at the start of each slot; must be >= 1
P_BLINK_FRAMES, 83, frames per blink half-period (~0.5 s)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  synchronous active-low reset
i_digits  input  24  digit k = i_digits[4k+3:4k]; k=0 is rightmost; 0x0-0xF
i_dp  input  6  decimal point request per digit
i_blink  input  6  blink enable per digit
i_lzb  input  1  leading-zero blanking enable
i_en  input  1  display enable
o_seg_enb  output  6  digit enables, active-low, at most one bit low
o_seg_dp  output  1  decimal point, active-high
o_seg  output  7  segments {a,b,c,d,e,f,g} = bits 6..0, active-high
o_frame_start  output  1  one-cycle pulse on the first cycle of digit-0 slot

Behaviour:
- One clock (clk); reset is synchronous and active-low on rst_n; all state updates on the rising edge.
- Reset (rst_n=0 at an edge): o_seg_enb=6'b111111, o_seg=0, o_seg_dp=0, o_frame_start=0; digit index=0, slot counter=0, blink phase=0 (visible), blink frame counter=0, shadow registers=0. Reset mid-slot aborts immediately.
- All outputs are registered. Cycle numbering c is counted from the o_frame_start cycle.
- o_frame_start first asserts on the 1st cycle after rst_n rises, then every 6*P_NUM_SCAN cycles.
- Slot structure: slot k covers c = k*P_NUM_SCAN .. (k+1)*P_NUM_SCAN-1.
- Internal FSM states: ST_BLANK and ST_SHOW.
  - ST_BLANK covers the first P_BLANK_CYC cycles of a slot: o_seg_enb=111111, o_seg=0, o_seg_dp=0.
  - ST_SHOW covers the remaining cycles.
  - At the end of the slot the FSM returns to ST_BLANK, and the index advances 0,1,...,5,0 (wrap).
- Slot-counter wrap 0..P_NUM_SCAN-1 uses $clog2 width; no other arithmetic.
- Shadow capture: i_digits, i_dp, i_blink and i_lzb are sampled on the edge that asserts o_frame_start. They are held for the whole frame; input changes mid-frame have no effect until the next frame.
- Leading-zero mask (computed at capture): with i_lzb=1, digits 5 down to 1 are blanked while they and all higher digits equal 0. Digit 0 is never blanked.
- ST_SHOW outputs for index k:
  - o_seg_enb[k]=0, all other bits 1.
  - o_seg = decode(digit k), or 0 if k is blanked.
  - o_seg_dp = shadow dp[k]; a blanked digit still shows its dp.
- Segment decode (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Blink:
  - The frame counter increments on each frame start.
  - On reaching P_BLINK_FRAMES it clears and toggles blink phase; the toggle takes effect from that frame.
  - When phase=1 and shadow blink[k]=1: o_seg=0 and o_seg_dp=0, with enable still driven.
- i_en=0: on the next cycle o_seg_enb=111111, o_seg=0, o_seg_dp=0. Scan, blink and o_frame_start keep running. When i_en returns to 1, the current slot/state resumes without resynchronising.
- Simultaneous slot end and frame wrap: index=0, shadow capture, blink update and o_frame_start all occur on the same edge.

Decomposition:
- Package disp_pkg holds:
  - NUM_DIGITS=6
  - the 16 segment-code constants
  - the state enum {ST_BLANK, ST_SHOW}
  - SEG_OFF=7'b0
  - ENB_NONE=6'b111111
- One sub-module, seg7_dec: combinational 4-bit code to 7-bit segment decoder; it is instantiated once on the shadow-muxed digit.

Test Plan:
All scenarios use P_NUM_SCAN=8, P_BLANK_CYC=2, P_BLINK_FRAMES=2.
- Reset: rst_n=0 for 5 cycles, then 1 -> during reset enb=111111, seg=0, dp=0, frame_start=0; frame_start=1 on the 1st cycle after release and again 48 cycles later.
- Scan: i_digits=24'h123456, i_lzb=0, i_dp=0 -> c=0..1 enb=111111; c=2..7 enb=111110, seg=1011111; c=42..47 enb=011111, seg=0110000.
- Shadow: change i_digits from 24'h123456 to 24'h999999 at c=20 -> c=26..31 still shows digit 3 value 3 (1111001); next frame digit 0 shows 1111011.
- LZB: i_digits=24'h000700, i_lzb=1, i_dp=6'b100000 -> digits 5,4,3 seg=0; digit 5 dp=1; digit 2 seg=1110000; digits 1,0 seg=1111110.
- Blink: i_blink=6'b000001, i_digits=24'h000008 -> digit 0 seg=1111111 in frames 0-1, seg=0 and dp=0 in frames 2-3, visible again in frame 4; digit 1 is unaffected throughout.
- Enable/reset mid-op: i_en=0 at c=4 -> outputs off from c=5 and frame_start pulses unchanged; rst_n=0 at c=30 -> reset values next edge, and the frame restarts after release.
